// File: rtl/des_pkg.sv
// des_pkg: shared constants and types for the DES key schedule.
//   PC1_TAB / PC2_TAB : 1-based DES bit numbers, MSB-first (bit 1 = highest index)
//   SHIFT_TAB         : per-round rotation amount (1 or 2)
//   state_t           : schedule FSM states
//   rot28             : 28-bit circular rotate by 1 or 2, left or right
package des_pkg;
  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // The table is symmetric about {1,8,15}, so the same lookup by the new
  // round index serves both the left (encrypt) and right (decrypt) walks.
  localparam int SHIFT_TAB [ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                              input logic two,
                                              input logic left);
    if (left)
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    else
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if: key-offer and subkey-stream handshakes.
//   master : key source / subkey consumer (drives key_valid, key_in, decrypt, subkey_ready)
//   slave  : the key schedule (drives key_ready, subkey_valid, subkey, round_idx, subkey_last)
interface des_key_schedule_if;
  import des_pkg::*;

  logic                key_valid;
  logic                key_ready;
  logic [KEY_W-1:0]    key_in;
  logic                decrypt;
  logic                subkey_valid;
  logic                subkey_ready;
  logic [SUBKEY_W-1:0] subkey;
  logic [3:0]          round_idx;
  logic                subkey_last;

  modport master (
    output key_valid, key_in, decrypt, subkey_ready,
    input  key_ready, subkey_valid, subkey, round_idx, subkey_last
  );

  modport slave (
    input  key_valid, key_in, decrypt, subkey_ready,
    output key_ready, subkey_valid, subkey, round_idx, subkey_last
  );
endinterface

// File: rtl/des_pc2.sv
// des_pc2: DES permuted choice 2, pure wiring.
//   cd  in  56 : {C,D}, cd[55] = C bit 1
//   k   out 48 : round subkey, k[47] = PC-2 bit 1
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] k
);

  always_comb begin
    k = '0;
    for (int i = 0; i < SUBKEY_W; i++)
      k[SUBKEY_W-1-i] = cd[CD_W - PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES key schedule, one 48-bit subkey per handshake,
// K1..K16 for encrypt or K16..K1 for decrypt.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : des_key_schedule_if.slave (key offer in, subkey stream out)
//
// state | meaning
// IDLE  | waiting for a key; key_ready=1, subkey_valid=0
// RUN   | presenting subkey round_idx; advances on each subkey handshake
module des_key_schedule
  import des_pkg::*;
(
  input  logic clk,
  input  logic rst,
  des_key_schedule_if.slave bus
);

  state_t            state_q, state_d;
  logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
  logic [3:0]        round_q, round_d;
  logic              dir_q, dir_d;
  logic [CD_W-1:0]   pc1_key;
  logic [3:0]        round_inc;
  logic              rot_two;

  always_comb begin
    pc1_key = '0;
    for (int i = 0; i < CD_W; i++)
      pc1_key[CD_W-1-i] = bus.key_in[KEY_W - PC1_TAB[i]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    round_d   = round_q;
    dir_d     = dir_q;
    round_inc = round_q + 4'd1;
    rot_two   = (SHIFT_TAB[round_inc] == 2);
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          state_d = RUN;
          round_d = '0;
          dir_d   = bus.decrypt;
          // Decrypt starts at K16, whose C,D equal the PC-1 value itself.
          if (bus.decrypt) begin
            c_d = pc1_key[CD_W-1:HALF_W];
            d_d = pc1_key[HALF_W-1:0];
          end else begin
            c_d = rot28(pc1_key[CD_W-1:HALF_W], 1'b0, 1'b1);
            d_d = rot28(pc1_key[HALF_W-1:0], 1'b0, 1'b1);
          end
        end
      end
      RUN: begin
        if (bus.subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            round_d = '0;
          end else begin
            round_d = round_inc;
            c_d     = rot28(c_q, rot_two, !dir_q);
            d_d     = rot28(d_q, rot_two, !dir_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .cd ({c_q, d_q}),
    .k  (bus.subkey)
  );

  assign bus.key_ready    = (state_q == IDLE);
  assign bus.subkey_valid = (state_q == RUN);
  assign bus.round_idx    = round_q;
  assign bus.subkey_last  = (state_q == RUN) && (round_q == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed bench for des_key_schedule with a scoreboard of
// expected subkeys pushed when a key is offered and popped on each subkey handshake.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;

  localparam int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TB_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic        stall_prev = 1'b0;
  logic [47:0] hold_sk;
  logic [3:0]  hold_idx;

  always #5 clk = ~clk;

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: K(rnd+1) from cumulative left shifts of the PC-1 halves.
  function automatic logic [47:0] model_key(input logic [63:0] key, input int rnd);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    int          tot;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64 - TB_PC1[i]];
    c   = cd[55:28];
    d   = cd[27:0];
    tot = 0;
    for (int j = 0; j <= rnd; j++) tot += TB_SHIFT[j];
    for (int j = 0; j < tot; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56 - TB_PC2[i]];
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_key(input logic [63:0] key, input logic dec);
    exp_t e;
    for (int n = 0; n < 16; n++) begin
      e.sk   = model_key(key, dec ? 15 - n : n);
      e.idx  = 4'(n);
      e.last = (n == 15);
      sb.push_back(e);
    end
  endtask

  task automatic push_zero();
    exp_t e;
    for (int n = 0; n < 16; n++) begin
      e.sk   = '0;
      e.idx  = 4'(n);
      e.last = (n == 15);
      sb.push_back(e);
    end
  endtask

  // Offer a key for one cycle starting just after a rising edge; returns just
  // after the accepting edge.
  task automatic offer_key(input logic [63:0] key, input logic dec);
    bus.key_in    = key;
    bus.decrypt   = dec;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_round(input logic [3:0] n);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.subkey_valid === 1'b1 && bus.round_idx === n) begin
        hit = 1'b1;
        break;
      end
    end
    chk("wait_round", 64'(hit), 64'd1);
  endtask

  task automatic wait_drain();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.key_ready === 1'b1 && sb.size() == 0) begin
        hit = 1'b1;
        break;
      end
    end
    chk("drain", 64'(hit), 64'd1);
  endtask

  // Scoreboard monitor and hold-under-backpressure check.
  always @(negedge clk) begin
    if (bus.subkey_valid === 1'b1) begin
      if (stall_prev) begin
        chk("hold_subkey", 64'(bus.subkey), 64'(hold_sk));
        chk("hold_idx", 64'(bus.round_idx), 64'(hold_idx));
      end
      if (bus.subkey_ready === 1'b1) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_subkey", 64'(bus.subkey), 64'(e.sk));
          chk("sb_idx", 64'(bus.round_idx), 64'(e.idx));
          chk("sb_last", 64'(bus.subkey_last), 64'(e.last));
        end
      end
      stall_prev = (bus.subkey_ready !== 1'b1);
      hold_sk    = bus.subkey;
      hold_idx   = bus.round_idx;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    rst              = 1'b1;
    bus.key_valid    = 1'b0;
    bus.key_in       = '0;
    bus.decrypt      = 1'b0;
    bus.subkey_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
    chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
    chk("rst_subkey", 64'(bus.subkey), 64'd0);
    chk("rst_idx", 64'(bus.round_idx), 64'd0);
    @(posedge clk);
    #1;

    // Encrypt known answers, ready tied high
    push_key(KEY_STD, 1'b0);
    offer_key(KEY_STD, 1'b0);
    @(negedge clk);
    chk("enc_r0_valid", 64'(bus.subkey_valid), 64'd1);
    chk("enc_r0_key_ready", 64'(bus.key_ready), 64'd0);
    chk("enc_r0", 64'(bus.subkey), 64'h1B02EFFC7072);
    @(negedge clk);
    chk("enc_r1", 64'(bus.subkey), 64'h79AED9DBC9E5);
    chk("enc_r1_last", 64'(bus.subkey_last), 64'd0);
    repeat (14) @(negedge clk);
    chk("enc_r15_idx", 64'(bus.round_idx), 64'd15);
    chk("enc_r15", 64'(bus.subkey), 64'hCB3D8B0E17F5);
    chk("enc_r15_last", 64'(bus.subkey_last), 64'd1);
    @(negedge clk);
    chk("enc_idle_key_ready", 64'(bus.key_ready), 64'd1);
    chk("enc_idle_valid", 64'(bus.subkey_valid), 64'd0);
    @(posedge clk);
    #1;

    // Decrypt known answers
    push_key(KEY_STD, 1'b1);
    offer_key(KEY_STD, 1'b1);
    @(negedge clk);
    chk("dec_r0", 64'(bus.subkey), 64'hCB3D8B0E17F5);
    repeat (14) @(negedge clk);
    chk("dec_r14", 64'(bus.subkey), 64'h79AED9DBC9E5);
    @(negedge clk);
    chk("dec_r15", 64'(bus.subkey), 64'h1B02EFFC7072);
    chk("dec_r15_last", 64'(bus.subkey_last), 64'd1);
    wait_drain();
    @(posedge clk);
    #1;

    // Random backpressure, random key, encrypt
    begin
      logic [63:0] rkey;
      rkey = {$urandom, $urandom};
      push_key(rkey, 1'b0);
      bus.subkey_ready = 1'b0;
      offer_key(rkey, 1'b0);
      for (int r = 0; r < 16; r++) begin
        int stall;
        stall = int'($urandom_range(0, 5));
        bus.subkey_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk);
          #1;
        end
        bus.subkey_ready = 1'b1;
        @(posedge clk);
        #1;
      end
      wait_drain();
    end
    @(posedge clk);
    #1;

    // Parity-only key difference gives all-zero subkeys
    push_zero();
    offer_key(64'h0000000000000000, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;
    push_zero();
    offer_key(64'h0101010101010101, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;

    // Reset mid-sequence at round 7
    push_key(KEY_STD, 1'b0);
    offer_key(KEY_STD, 1'b0);
    wait_round(4'd7);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.subkey_valid), 64'd0);
    chk("midrst_key_ready", 64'(bus.key_ready), 64'd1);
    chk("midrst_idx", 64'(bus.round_idx), 64'd0);
    chk("midrst_subkey", 64'(bus.subkey), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_key(KEY_STD, 1'b0);
    offer_key(KEY_STD, 1'b0);
    @(negedge clk);
    chk("postrst_r0", 64'(bus.subkey), 64'h1B02EFFC7072);
    wait_drain();
    @(posedge clk);
    #1;

    // key_valid held through RUN with a different key
    push_key(KEY_STD, 1'b0);
    push_key(KEY_B, 1'b0);
    bus.key_in    = KEY_STD;
    bus.decrypt   = 1'b0;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_in = KEY_B;
    repeat (16) @(negedge clk);
    chk("hold_r15_idx", 64'(bus.round_idx), 64'd15);
    chk("hold_r15_key_ready", 64'(bus.key_ready), 64'd0);
    @(negedge clk);
    chk("hold_idle_key_ready", 64'(bus.key_ready), 64'd1);
    chk("hold_idle_valid", 64'(bus.subkey_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    @(negedge clk);
    chk("second_r0_valid", 64'(bus.subkey_valid), 64'd1);
    chk("second_r0", 64'(bus.subkey), 64'(model_key(KEY_B, 0)));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
